// File: rtl/pzvip_tilelink_types_pkg.sv
// rtl/pzvip_tilelink_types_pkg.sv - TileLink channel/error enums and opcode decode helpers
package pzvip_tilelink_types_pkg;

    typedef enum logic [1:0] {
        PZVIP_TILELINK_CHANNEL_A = 2'd0,
        PZVIP_TILELINK_CHANNEL_B = 2'd1,
        PZVIP_TILELINK_CHANNEL_C = 2'd2,
        PZVIP_TILELINK_CHANNEL_D = 2'd3
    } pzvip_tilelink_channel;

    typedef enum logic [1:0] {
        TRACKER_ERROR_NONE          = 2'd0,
        TRACKER_ERROR_HEADER_CHANGE = 2'd1,
        TRACKER_ERROR_VALID_DROP    = 2'd2,
        TRACKER_ERROR_SIZE_ILLEGAL  = 2'd3
    } pzvip_tilelink_tracker_error;

    typedef enum logic {
        TRACKER_IDLE  = 1'b0,
        TRACKER_BURST = 1'b1
    } pzvip_tilelink_tracker_state;

    function automatic int tracker_beat_width(input int data_width, input int max_size_log2);
        int w;
        w = max_size_log2 - $clog2(data_width / 8);
        return (w > 1) ? w : 1;
    endfunction

    function automatic logic is_channel_opcode_having_data(
        input pzvip_tilelink_channel channel,
        input logic [2:0]            opcode
    );
        case (channel)
            PZVIP_TILELINK_CHANNEL_A, PZVIP_TILELINK_CHANNEL_B: return opcode <= 3'd3;
            PZVIP_TILELINK_CHANNEL_C: return (opcode == 3'd1) || (opcode == 3'd5) || (opcode == 3'd7);
            default:                  return (opcode == 3'd1) || (opcode == 3'd5);
        endcase
    endfunction

endpackage

// File: rtl/pzvip_tilelink_beat_calc.sv
// rtl/pzvip_tilelink_beat_calc.sv - combinational (channel, opcode, size) to last beat index
module pzvip_tilelink_beat_calc
    import pzvip_tilelink_types_pkg::*;
#(
    parameter int  DATA_WIDTH    = 64,
    parameter int  MAX_SIZE_LOG2 = 12,
    localparam int SIZE_WIDTH    = $clog2(MAX_SIZE_LOG2 + 1),
    localparam int BEAT_WIDTH    = tracker_beat_width(DATA_WIDTH, MAX_SIZE_LOG2)
)(
    input  logic [1:0]            i_channel,
    input  logic [2:0]            i_opcode,
    input  logic [SIZE_WIDTH-1:0] i_size,
    output logic [BEAT_WIDTH-1:0] o_last_index,
    output logic                  o_size_illegal
);
    localparam int BYTES_LOG2 = $clog2(DATA_WIDTH / 8);
    localparam int CALC_WIDTH = MAX_SIZE_LOG2 + 1;

    logic                  w_has_data;
    logic [CALC_WIDTH-1:0] w_last_index;

    assign w_has_data     = is_channel_opcode_having_data(pzvip_tilelink_channel'(i_channel), i_opcode);
    assign o_size_illegal = i_size > SIZE_WIDTH'(MAX_SIZE_LOG2);

    // Oversized data messages saturate at 2^BEAT_WIDTH beats.
    always_comb begin
        w_last_index = '0;
        if (w_has_data) begin
            if (o_size_illegal) begin
                w_last_index = {CALC_WIDTH{1'b1}} >> (CALC_WIDTH - BEAT_WIDTH);
            end else if (i_size > SIZE_WIDTH'(BYTES_LOG2)) begin
                w_last_index = (CALC_WIDTH'(1) << (i_size - SIZE_WIDTH'(BYTES_LOG2))) - CALC_WIDTH'(1);
            end
        end
    end

    assign o_last_index = BEAT_WIDTH'(w_last_index);

endmodule

// File: rtl/pzvip_tilelink_message_tracker.sv
// rtl/pzvip_tilelink_message_tracker.sv - per-channel TileLink beat counter with done pulse
// Protocol error checks compiled in with PZVIP_TILELINK_MESSAGE_TRACKER_CHECK_EN.
module pzvip_tilelink_message_tracker
    import pzvip_tilelink_types_pkg::*;
#(
    parameter int  CHANNEL       = 0,
    parameter int  DATA_WIDTH    = 64,
    parameter int  ADDRESS_WIDTH = 64,
    parameter int  SOURCE_WIDTH  = 8,
    parameter int  MAX_SIZE_LOG2 = 12,
    localparam int SIZE_WIDTH    = $clog2(MAX_SIZE_LOG2 + 1),
    localparam int BEAT_WIDTH    = tracker_beat_width(DATA_WIDTH, MAX_SIZE_LOG2)
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic                     i_ready,
    input  logic [2:0]               i_opcode,
    input  logic [2:0]               i_param,
    input  logic [SIZE_WIDTH-1:0]    i_size,
    input  logic [SOURCE_WIDTH-1:0]  i_source,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    output logic                     o_first,
    output logic                     o_last,
    output logic [BEAT_WIDTH-1:0]    o_beat_index,
    output logic                     o_message_done,
    output logic                     o_error,
    output logic [1:0]               o_error_code
);
    pzvip_tilelink_tracker_state r_state;
    logic [BEAT_WIDTH-1:0]       r_count;
    logic [2:0]                  r_opcode;
    logic [SIZE_WIDTH-1:0]       r_size;
    logic                        r_message_done;

    logic [1:0]                  w_channel;
    logic                        w_accept;
    logic                        w_start_burst;
    logic [BEAT_WIDTH-1:0]       w_live_last_index;
    logic [BEAT_WIDTH-1:0]       w_captured_last_index;
    logic                        w_live_size_illegal;
    logic                        w_captured_size_unused;

    assign w_channel = 2'(CHANNEL);
    assign w_accept  = i_valid && i_ready;

    pzvip_tilelink_beat_calc #(
        .DATA_WIDTH    (DATA_WIDTH),
        .MAX_SIZE_LOG2 (MAX_SIZE_LOG2)
    ) u_live_calc (
        .i_channel      (w_channel),
        .i_opcode       (i_opcode),
        .i_size         (i_size),
        .o_last_index   (w_live_last_index),
        .o_size_illegal (w_live_size_illegal)
    );

    pzvip_tilelink_beat_calc #(
        .DATA_WIDTH    (DATA_WIDTH),
        .MAX_SIZE_LOG2 (MAX_SIZE_LOG2)
    ) u_captured_calc (
        .i_channel      (w_channel),
        .i_opcode       (r_opcode),
        .i_size         (r_size),
        .o_last_index   (w_captured_last_index),
        .o_size_illegal (w_captured_size_unused)
    );

    // In IDLE the message length comes from the live header, in BURST from the captured one.
    assign o_first        = (r_state == TRACKER_IDLE);
    assign o_last         = (r_count == (o_first ? w_live_last_index : w_captured_last_index));
    assign o_beat_index   = r_count;
    assign o_message_done = r_message_done;
    assign w_start_burst  = o_first && w_accept && (w_live_last_index != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= TRACKER_IDLE;
            r_count        <= '0;
            r_opcode       <= '0;
            r_size         <= '0;
            r_message_done <= 1'b0;
        end else begin
            r_message_done <= w_accept && o_last;
            case (r_state)
                TRACKER_IDLE: begin
                    if (w_start_burst) begin
                        r_state  <= TRACKER_BURST;
                        r_count  <= BEAT_WIDTH'(1);
                        r_opcode <= i_opcode;
                        r_size   <= i_size;
                    end
                end
                TRACKER_BURST: begin
                    if (w_accept) begin
                        if (o_last) begin
                            r_state <= TRACKER_IDLE;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PZVIP_TILELINK_MESSAGE_TRACKER_CHECK_EN
    localparam int HEADER_WIDTH = 6 + SIZE_WIDTH + SOURCE_WIDTH + ADDRESS_WIDTH;

    logic [HEADER_WIDTH-1:0]     r_header;
    logic [HEADER_WIDTH-1:0]     r_prev_header;
    logic                        r_prev_hold;
    logic                        r_error;
    pzvip_tilelink_tracker_error r_error_code;

    logic [HEADER_WIDTH-1:0]     w_live_header;
    logic                        w_header_change;
    logic                        w_valid_drop;
    logic                        w_size_illegal;

    assign w_live_header   = {i_opcode, i_param, i_size, i_source, i_address};
    assign w_header_change = (r_state == TRACKER_BURST) && i_valid && (w_live_header != r_header);
    assign w_valid_drop    = r_prev_hold && (!i_valid || (w_live_header != r_prev_header));
    assign w_size_illegal  = i_valid && w_live_size_illegal;

    // Only the first error is recorded; it stays until reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_header      <= '0;
            r_prev_header <= '0;
            r_prev_hold   <= 1'b0;
            r_error       <= 1'b0;
            r_error_code  <= TRACKER_ERROR_NONE;
        end else begin
            r_prev_hold   <= i_valid && !i_ready;
            r_prev_header <= w_live_header;
            if (w_start_burst) begin
                r_header <= w_live_header;
            end
            if (!r_error) begin
                if (w_header_change) begin
                    r_error      <= 1'b1;
                    r_error_code <= TRACKER_ERROR_HEADER_CHANGE;
                end else if (w_valid_drop) begin
                    r_error      <= 1'b1;
                    r_error_code <= TRACKER_ERROR_VALID_DROP;
                end else if (w_size_illegal) begin
                    r_error      <= 1'b1;
                    r_error_code <= TRACKER_ERROR_SIZE_ILLEGAL;
                end
            end
        end
    end

    assign o_error      = r_error;
    assign o_error_code = r_error_code;
`else
    logic w_unused_inputs;

    assign w_unused_inputs = ^{i_param, i_source, i_address, w_live_size_illegal};
    assign o_error         = 1'b0;
    assign o_error_code    = 2'd0;
`endif

endmodule

// File: tb/tb_pzvip_tilelink_message_tracker.sv
// tb/tb_pzvip_tilelink_message_tracker.sv - scoreboard bench over A, C and D tracker instances
module tb_pzvip_tilelink_message_tracker;
    localparam int DATA_WIDTH    = 64;
    localparam int ADDRESS_WIDTH = 64;
    localparam int SOURCE_WIDTH  = 8;
    localparam int MAX_SIZE_LOG2 = 12;
    localparam int SIZE_W        = $clog2(MAX_SIZE_LOG2 + 1);
    localparam int BEAT_W_RAW    = MAX_SIZE_LOG2 - $clog2(DATA_WIDTH / 8);
    localparam int BEAT_W        = (BEAT_W_RAW > 1) ? BEAT_W_RAW : 1;
`ifdef PZVIP_TILELINK_MESSAGE_TRACKER_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    typedef struct packed {
        logic [2:0]       first;
        logic [2:0]       last;
        logic [2:0][15:0] idx;
    } exp_t;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic                     i_valid = 1'b0;
    logic                     i_ready = 1'b0;
    logic [2:0]               i_opcode = '0;
    logic [2:0]               i_param = '0;
    logic [SIZE_W-1:0]        i_size = '0;
    logic [SOURCE_WIDTH-1:0]  i_source = '0;
    logic [ADDRESS_WIDTH-1:0] i_address = '0;

    logic              dut_first [3];
    logic              dut_last  [3];
    logic [BEAT_W-1:0] dut_idx   [3];
    logic              dut_done  [3];
    logic              dut_err   [3];
    logic [1:0]        dut_code  [3];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 i_clk = ~i_clk;

    function automatic int chan_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        pzvip_tilelink_message_tracker #(
            .CHANNEL       (CH),
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .SOURCE_WIDTH  (SOURCE_WIDTH),
            .MAX_SIZE_LOG2 (MAX_SIZE_LOG2)
        ) u_dut (
            .i_clk          (i_clk),
            .i_rst_n        (i_rst_n),
            .i_valid        (i_valid),
            .i_ready        (i_ready),
            .i_opcode       (i_opcode),
            .i_param        (i_param),
            .i_size         (i_size),
            .i_source       (i_source),
            .i_address      ((CH == 3) ? {ADDRESS_WIDTH{1'b0}} : i_address),
            .o_first        (dut_first[g]),
            .o_last         (dut_last[g]),
            .o_beat_index   (dut_idx[g]),
            .o_message_done (dut_done[g]),
            .o_error        (dut_err[g]),
            .o_error_code   (dut_code[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: beats = data ? max(1, 2^size / bus bytes) : 1, saturating when oversized.
    function automatic int model_beats(input int ch, input int op, input int size);
        bit data;
        int b;
        case (ch)
            0, 1:    data = (op < 4);
            2:       data = (op == 1) || (op == 5) || (op == 7);
            default: data = (op == 1) || (op == 5);
        endcase
        if (!data) return 1;
        if (size > MAX_SIZE_LOG2) return 1 << BEAT_W;
        b = (1 << size) / (DATA_WIDTH / 8);
        return (b > 1) ? b : 1;
    endfunction

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            i_ready = 1'($urandom_range(0, 1));
            @(posedge i_clk); #1;
        end
    endtask

    task automatic send_msg(input int op, input int sz, input bit stall, input int src_chg, input int abort_at);
        int   n[3];
        int   nmax;
        int   stalls;
        exp_t e;
        nmax = 1;
        for (int k = 0; k < 3; k++) begin
            n[k] = model_beats(chan_of(k), op, sz);
            if (n[k] > nmax) nmax = n[k];
        end
        i_opcode  = 3'(op);
        i_size    = SIZE_W'(sz);
        i_param   = 3'($urandom);
        i_source  = SOURCE_WIDTH'($urandom);
        i_address = {$urandom, $urandom};
        for (int b = 0; b < nmax; b++) begin
            if (b == src_chg) i_source = i_source ^ 1'b1;
            for (int k = 0; k < 3; k++) begin
                e.idx[k]   = 16'(b % n[k]);
                e.first[k] = (b % n[k]) == 0;
                e.last[k]  = (b % n[k]) == n[k] - 1;
            end
            exp_q.push_back(e);
            i_valid = 1'b1;
            stalls  = 0;
            do begin
                i_ready = !stall || stalls >= 3 || ($urandom_range(0, 2) != 0);
                stalls++;
                @(posedge i_clk); #1;
            end while (!i_ready);
            if (b == abort_at) break;
        end
    endtask

    task automatic chk_err(input string tag, input int ca, input int cc, input int cd);
        int c[3];
        c = '{ca, cc, cd};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_error_ch%0d", tag, chan_of(k)), dut_err[k], (c[k] != 0) ? 1 : 0);
            chk($sformatf("%s_code_ch%0d", tag, chan_of(k)), dut_code[k], c[k]);
        end
    endtask

    always @(negedge i_clk) begin : monitor
        exp_t       e;
        logic [2:0] pend_done;
        if (!i_rst_n) begin
            pend_done = '0;
        end else begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("done_ch%0d", chan_of(k)), dut_done[k], pend_done[k]);
            pend_done = '0;
            if (i_valid) begin
                if (exp_q.size() == 0) begin
                    if (i_ready) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: accepted beat with empty scoreboard");
                    end
                end else begin
                    e = exp_q[0];
                    for (int k = 0; k < 3; k++) begin
                        chk($sformatf("first_ch%0d", chan_of(k)), dut_first[k], e.first[k]);
                        chk($sformatf("last_ch%0d", chan_of(k)), dut_last[k], e.last[k]);
                        chk($sformatf("index_ch%0d", chan_of(k)), dut_idx[k], e.idx[k]);
                    end
                    if (i_ready) begin
                        void'(exp_q.pop_front());
                        pend_done = e.last;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500us;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) @(posedge i_clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_first_ch%0d", chan_of(k)), dut_first[k], 1);
            chk($sformatf("reset_last_ch%0d", chan_of(k)), dut_last[k], 1);
            chk($sformatf("reset_index_ch%0d", chan_of(k)), dut_idx[k], 0);
            chk($sformatf("reset_done_ch%0d", chan_of(k)), dut_done[k], 0);
        end
        chk_err("reset", 0, 0, 0);
        #2 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        send_msg(0, 6, 1'b0, -1, -1);
        idle(2);
        send_msg(4, 6, 1'b0, -1, -1);
        send_msg(4, 6, 1'b0, -1, -1);
        idle(2);
        send_msg(1, 2, 1'b0, -1, -1);
        send_msg(5, 6, 1'b1, -1, -1);
        idle(1);
        for (int m = 0; m < 20; m++) begin
            send_msg($urandom_range(0, 7), $urandom_range(0, 9), 1'b1, -1, -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(2);
        chk_err("clean", 0, 0, 0);

        send_msg(0, 6, 1'b0, 3, -1);
        idle(2);
        chk_err("hdr_change", CHK, 0, 0);

        i_opcode = 3'd0;
        i_size   = '0;
        i_valid  = 1'b1;
        i_ready  = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        chk_err("valid_drop", CHK, CHK * 2, CHK * 2);

        send_msg(0, 6, 1'b0, -1, 4);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort_first_ch%0d", chan_of(k)), dut_first[k], 1);
            chk($sformatf("abort_index_ch%0d", chan_of(k)), dut_idx[k], 0);
            chk($sformatf("abort_done_ch%0d", chan_of(k)), dut_done[k], 0);
        end
        chk_err("abort", 0, 0, 0);
        exp_q.delete();
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        send_msg(0, 6, 1'b1, -1, -1);
        idle(2);
        chk_err("after_abort", 0, 0, 0);

        send_msg(0, 13, 1'b0, -1, -1);
        idle(3);
        chk_err("size_illegal", CHK * 3, CHK * 3, CHK * 3);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
